chan_edge_capture: RTL and testbench

Per-channel input conditioner for the BiDirChannels IP. It synchronizes a raw pad input through a two-flop chain and glitch-filters it to a stable level. It then detects edges according to a programmable mode and queues timestamped edge events in a small FIFO, which the channel register interface drains via valid/ready. It sits downstream of the channel pad flop and upstream of the register and interrupt logic.

---
 rtl/bidir_chan_pkg.sv | 25 ++
 rtl/chan_edge_capture_if.sv | 13 +
 rtl/chan_evt_fifo.sv | 58 +++++
 rtl/chan_edge_capture.sv | 90 +++++++++
 tb/tb_chan_edge_capture.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bidir_chan_pkg.sv
// Shared types for the BiDirChannels per-channel capture path: edge modes,
// the queued event payload and the saturating edge counter width.
package bidir_chan_pkg;

  localparam int EDGE_CNT_W = 16;
  localparam int EVT_TS_W   = 32;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2,
    EDGE_BOTH = 2'd3
  } edge_mode_t;

  typedef struct packed {
    logic [EVT_TS_W-1:0] ts;
    logic                pol;
  } evt_t;

  // pol: 1 = rising edge, 0 = falling edge
  function automatic logic edge_match(input edge_mode_t mode, input logic pol);
    return (mode == EDGE_BOTH) || (mode == EDGE_RISE && pol) || (mode == EDGE_FALL && !pol);
  endfunction

endpackage

// File: rtl/chan_edge_capture_if.sv
// Event drain handshake between the capture block and the channel register
// interface; the head event is held stable while valid is high and ready is low.
interface chan_edge_capture_if #(
  parameter int TS_W = 32
);
  logic            evt_valid;
  logic            evt_ready;
  logic [TS_W-1:0] evt_ts;
  logic            evt_pol;

  modport master (output evt_valid, output evt_ts, output evt_pol, input evt_ready);
  modport slave  (input evt_valid, input evt_ts, input evt_pol, output evt_ready);
endinterface

// File: rtl/chan_evt_fifo.sv
// Synchronous event FIFO with a registered head: a push into an empty FIFO is
// visible one cycle later; pops are valid&ready; a push when full is refused unless a pop frees a slot.
module chan_evt_fifo
  import bidir_chan_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  evt_t                   push_dat,
  output logic                   full,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output evt_t                   out_dat,
  output logic [$clog2(DEPTH):0] cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  evt_t            mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   rd_nxt;
  logic [CW-1:0]   cnt_after_pop;
  logic            pop;
  logic            wr_en;

  assign full          = (cnt == CW'(DEPTH));
  assign pop           = out_vld && out_rdy;
  assign wr_en         = push && (!full || pop);
  assign rd_nxt        = rd_ptr + AW'(pop);
  assign cnt_after_pop = cnt - CW'(pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_dat;
  end

  // The head register reloads from the slot after a pop, so a freshly written
  // slot is never read in its write cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      out_vld <= 1'b0;
      out_dat <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr  <= rd_nxt;
      cnt     <= cnt_after_pop + CW'(wr_en);
      out_vld <= (cnt_after_pop != '0);
      out_dat <= (cnt_after_pop != '0) ? mem[rd_nxt] : '0;
    end
  end

endmodule

// File: rtl/chan_edge_capture.sv
// Pad input conditioner: 2-flop sync, glitch filter, mode-selected edge detect, timestamped event queue.
// Pad-to-level latency 3+filt_cyc edges; events wait in the FIFO under backpressure and overflow drops set ovf.
module chan_edge_capture
  import bidir_chan_pkg::*;
#(
  parameter int TS_W   = EVT_TS_W,
  parameter int FILT_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pad_in,
  input  logic                    en,
  input  logic [1:0]              edge_mode,
  input  logic [FILT_W-1:0]       filt_cyc,
  input  logic                    ts_clr,
  input  logic                    ovf_clr,
  chan_edge_capture_if.master     evt,
  output logic                    level,
  output logic [EDGE_CNT_W-1:0]   edge_cnt,
  output logic                    ovf,
  output logic [$clog2(DEPTH):0]  fifo_cnt
);

  logic              s1;
  logic              s2;
  logic [FILT_W-1:0] fcnt;
  logic [TS_W-1:0]   ts_q;
  logic              accept;
  logic              detect;
  logic              fifo_full;
  logic              pop;
  evt_t              push_dat;
  evt_t              head;

  // >= so that lowering filt_cyc below a running count accepts at once
  assign accept   = (s2 != level) && (fcnt >= filt_cyc);
  assign detect   = accept && en && edge_match(edge_mode_t'(edge_mode), s2);
  assign pop      = evt.evt_valid && evt.evt_ready;
  assign push_dat = '{ts: ts_q, pol: s2};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      level    <= 1'b0;
      fcnt     <= '0;
      ts_q     <= '0;
      edge_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      s1   <= pad_in;
      s2   <= s1;
      ts_q <= ts_clr ? '0 : ts_q + TS_W'(1);

      if (s2 == level) begin
        fcnt <= '0;
      end else if (accept) begin
        level <= s2;
        fcnt  <= '0;
      end else begin
        fcnt <= fcnt + FILT_W'(1);
      end

      if (detect && edge_cnt != '1) edge_cnt <= edge_cnt + EDGE_CNT_W'(1);

      // A new drop outranks a clear in the same cycle
      if (detect && fifo_full && !pop) ovf <= 1'b1;
      else if (ovf_clr)                ovf <= 1'b0;
    end
  end

  chan_evt_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (detect),
    .push_dat (push_dat),
    .full     (fifo_full),
    .out_vld  (evt.evt_valid),
    .out_rdy  (evt.evt_ready),
    .out_dat  (head),
    .cnt      (fifo_cnt)
  );

  assign evt.evt_ts  = head.ts;
  assign evt.evt_pol = head.pol;

endmodule

// File: tb/tb_chan_edge_capture.sv
// Randomized and directed bench for chan_edge_capture against a queue-based
// reference model driven by the pad sample history.
module tb_chan_edge_capture;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pad_in;
  logic        en;
  logic [1:0]  edge_mode;
  logic [7:0]  filt_cyc;
  logic        ts_clr;
  logic        ovf_clr;
  logic        level;
  logic [15:0] edge_cnt;
  logic        ovf;
  logic [3:0]  fifo_cnt;

  chan_edge_capture_if #(.TS_W(32)) evt_if ();

  chan_edge_capture #(.TS_W(32), .FILT_W(8), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pad_in    (pad_in),
    .en        (en),
    .edge_mode (edge_mode),
    .filt_cyc  (filt_cyc),
    .ts_clr    (ts_clr),
    .ovf_clr   (ovf_clr),
    .evt       (evt_if.master),
    .level     (level),
    .edge_cnt  (edge_cnt),
    .ovf       (ovf),
    .fifo_cnt  (fifo_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the filter accepts when the last filt_cyc+1 synchronized
  // samples all differ from the current level; events live in a plain queue.
  typedef struct {
    logic [31:0] ts;
    bit          pol;
  } mevt_t;

  bit          pads[$];
  mevt_t       q[$];
  bit          m_level;
  logic [31:0] m_ts;
  int          m_ecnt;
  bit          m_ovf;
  bit          m_vld;
  bit          chk_on;
  bit          acc, s2v, det, pop;
  int          sz;

  always @(posedge clk) begin
    if (!rst_n) begin
      pads.delete();
      q.delete();
      m_level = 0; m_ts = 0; m_ecnt = 0; m_ovf = 0; m_vld = 0;
    end else begin
      s2v = (pads.size() > 1) ? pads[1] : 1'b0;
      acc = 1;
      for (int i = 1; i <= int'(filt_cyc) + 1; i++)
        if (((pads.size() > i) ? pads[i] : 1'b0) == m_level) acc = 0;
      det = acc && en && (edge_mode == 2'd3 || (edge_mode == 2'd1 && s2v) || (edge_mode == 2'd2 && !s2v));
      pop = m_vld && evt_if.evt_ready;
      sz  = q.size();
      if (pop) void'(q.pop_front());
      m_vld = (sz - int'(pop)) > 0;
      if (ovf_clr) m_ovf = 0;
      if (det) begin
        if (m_ecnt < 65535) m_ecnt++;
        if (sz < DEPTH || pop) q.push_back('{m_ts, s2v});
        else m_ovf = 1;
      end
      if (acc) m_level = s2v;
      m_ts = ts_clr ? 32'd0 : m_ts + 32'd1;
      pads.push_front(pad_in);
      if (pads.size() > 300) void'(pads.pop_back());
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("mdl_level", level, m_level);
      chk("mdl_valid", evt_if.evt_valid, m_vld);
      chk("mdl_fifo_cnt", fifo_cnt, q.size());
      chk("mdl_edge_cnt", edge_cnt, m_ecnt);
      chk("mdl_ovf", ovf, m_ovf);
      if (m_vld) begin
        chk("mdl_head_ts", evt_if.evt_ts, q[0].ts);
        chk("mdl_head_pol", evt_if.evt_pol, q[0].pol);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  logic [31:0] got_ts[$];
  int          n;

  initial begin
    chk_on = 0;
    rst_n = 1'b0; pad_in = 1'b0; en = 1'b1; edge_mode = 2'd3; filt_cyc = 8'd0;
    ts_clr = 1'b0; ovf_clr = 1'b0; evt_if.evt_ready = 1'b0;
    cyc(3);
    chk("rst_valid", evt_if.evt_valid, 0);
    chk("rst_fifo_cnt", fifo_cnt, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_edge_cnt", edge_cnt, 0);
    chk("rst_level", level, 0);
    chk("rst_ts", evt_if.evt_ts, 0);
    chk("rst_pol", evt_if.evt_pol, 0);
    chk_on = 1;
    rst_n = 1'b1;
    cyc(5);

    // Minimum pad-to-level latency with filt_cyc=0
    pad_in = 1'b1;
    n = 0;
    while (level !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rise_latency", n, 3);
    cyc(2);
    chk("t1_edge_cnt", edge_cnt, 1);
    chk("t1_valid", evt_if.evt_valid, 1);
    chk("t1_pol", evt_if.evt_pol, 1);

    // Glitch rejection and a pulse that survives filt_cyc=4
    pad_in = 1'b0;
    do_reset();
    filt_cyc = 8'd4;
    cyc(3);
    pad_in = 1'b1; cyc(3); pad_in = 1'b0;
    cyc(12);
    chk("glitch_level", level, 0);
    chk("glitch_edge_cnt", edge_cnt, 0);
    pad_in = 1'b1; cyc(6); pad_in = 1'b0;
    cyc(15);
    chk("pulse_edge_cnt", edge_cnt, 2);
    chk("pulse_fifo_cnt", fifo_cnt, 2);

    // Rise-only mode, three pulses, then ordered drain
    filt_cyc = 8'd0; edge_mode = 2'd1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pad_in = 1'b1; cyc(4); pad_in = 1'b0; cyc(4);
    end
    chk("rise3_fifo_cnt", fifo_cnt, 3);
    chk("rise3_edge_cnt", edge_cnt, 3);
    got_ts.delete();
    evt_if.evt_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (evt_if.evt_valid) begin
        got_ts.push_back(evt_if.evt_ts);
        chk("drain_pol", evt_if.evt_pol, 1);
      end
      cyc(1);
    end
    evt_if.evt_ready = 1'b0;
    chk("drain_count", got_ts.size(), 3);
    for (int i = 1; i < got_ts.size(); i++)
      chk("drain_order", got_ts[i] > got_ts[i-1], 1);

    // Overflow with ten rises, then push+pop at full
    do_reset();
    for (int i = 0; i < 10; i++) begin
      pad_in = 1'b1; cyc(2); pad_in = 1'b0; cyc(2);
    end
    cyc(4);
    chk("ovf_fifo_cnt", fifo_cnt, 8);
    chk("ovf_flag", ovf, 1);
    chk("ovf_edge_cnt", edge_cnt, 10);
    ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0;
    chk("ovf_clr", ovf, 0);
    pad_in = 1'b1;
    cyc(2);
    evt_if.evt_ready = 1'b1;
    cyc(1);
    evt_if.evt_ready = 1'b0;
    chk("full_pp_fifo_cnt", fifo_cnt, 8);
    chk("full_pp_ovf", ovf, 0);
    chk("full_pp_edge_cnt", edge_cnt, 11);
    pad_in = 1'b0;
    cyc(4);

    // Timestamp wrap and ts_clr in an accept cycle
    edge_mode = 2'd3;
    do_reset();
    cyc(3);
    force dut.ts_q = 32'hFFFF_FFFE;
    m_ts = 32'hFFFF_FFFE;
    pad_in = 1'b1;
    #1 release dut.ts_q;
    cyc(4);
    chk("wrap_ts", evt_if.evt_ts, 0);
    chk("wrap_pol", evt_if.evt_pol, 1);
    pad_in = 1'b0;
    cyc(2);
    ts_clr = 1'b1;
    cyc(1);
    ts_clr = 1'b0;
    chk("ts_clr_cnt", dut.ts_q, 0);
    chk("ts_clr_fifo_cnt", fifo_cnt, 2);
    evt_if.evt_ready = 1'b1; cyc(5); evt_if.evt_ready = 1'b0;

    // Reset with five queued events
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pad_in = ~pad_in; cyc(3);
    end
    cyc(2);
    chk("pre_rst_fifo_cnt", fifo_cnt, 5);
    rst_n = 1'b0;
    cyc(1);
    chk("mid_rst_valid", evt_if.evt_valid, 0);
    chk("mid_rst_fifo_cnt", fifo_cnt, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_edge_cnt", edge_cnt, 0);
    chk("mid_rst_level", level, 0);
    pad_in = 1'b0;
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) pad_in = ~pad_in;
      evt_if.evt_ready = ($urandom_range(0, 3) == 0);
      ts_clr  = ($urandom_range(0, 60) == 0);
      ovf_clr = ($urandom_range(0, 40) == 0);
      en      = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 100) == 0) edge_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 80) == 0)  filt_cyc  = 8'($urandom_range(0, 5));
      rst_n = ($urandom_range(0, 700) != 0);
      cyc(1);
    end
    rst_n = 1'b1;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
